// File: rtl/sa_autosa_sdp_rdma_pack_arb.sv
// Frame-locked round-robin arbiter feeding one registered word per cycle into the
// SDP RDMA pack input; a requester keeps the datapath until its frame-last word.
module sa_autosa_sdp_rdma_pack_arb #(
  parameter int IW = 512,
  parameter int CW = 1,
  parameter int NR = 3
) (
  input  logic                     autosa_core_clk,
  input  logic                     autosa_core_rstn,
  input  logic [NR-1:0]            cfg_req_en,
  input  logic [NR-1:0]            req_pvld,
  input  logic [NR*(IW+CW)-1:0]    req_data,
  output logic [NR-1:0]            req_prdy,
  output logic                     out_pvld,
  output logic [IW+CW-1:0]         out_data,
  input  logic                     out_prdy,
  output logic [1:0]               arb_owner,
  output logic                     arb_locked,
  output logic [NR-1:0]            frame_done
);

  localparam int DW = IW + CW;

  typedef enum logic {ST_IDLE, ST_LOCK} st_t;

  st_t             r_state, w_state_nxt;
  logic [1:0]      r_ptr, r_owner, w_ptr_nxt, w_owner_nxt;
  logic            r_out_pvld;
  logic [DW-1:0]   r_out_data;
  logic [NR-1:0]   r_frame_done, w_done_nxt;

  logic            w_stage_rdy, w_found, w_gv, w_acc, w_last, w_pvld_g;
  logic [1:0]      w_rr_idx, w_g;
  logic [DW-1:0]   w_word;
  logic [NR-1:0]   w_elig;

  assign w_stage_rdy = !r_out_pvld | out_prdy;
  assign w_elig      = cfg_req_en & req_pvld;

  // Pick the eligible requester closest after ptr in circular order.
  always_comb begin
    int best_d;
    int d;
    best_d   = NR;
    d        = 0;
    w_found  = 1'b0;
    w_rr_idx = '0;
    for (int i = 0; i < NR; i++) begin
      d = (i + NR - 1 - int'(r_ptr)) % NR;
      if (w_elig[i] && d < best_d) begin
        best_d   = d;
        w_found  = 1'b1;
        w_rr_idx = 2'(i);
      end
    end
  end

  always_comb begin
    w_g      = (r_state == ST_LOCK) ? r_owner : w_rr_idx;
    w_gv     = (r_state == ST_LOCK) | w_found;
    w_word   = '0;
    w_pvld_g = 1'b0;
    req_prdy = '0;
    for (int i = 0; i < NR; i++) begin
      if (w_g == 2'(i)) begin
        w_word      = req_data[i*DW +: DW];
        w_pvld_g    = req_pvld[i];
        req_prdy[i] = w_gv & w_stage_rdy & autosa_core_rstn;
      end
    end
  end

  assign w_acc  = w_gv & w_pvld_g & w_stage_rdy & autosa_core_rstn;
  assign w_last = w_word[IW];

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_owner_nxt = r_owner;
    w_done_nxt  = '0;
    if (w_acc) begin
      if (r_state == ST_IDLE) w_owner_nxt = w_g;
      if (w_last) begin
        w_state_nxt = ST_IDLE;
        w_ptr_nxt   = w_g;
        for (int i = 0; i < NR; i++) w_done_nxt[i] = (w_g == 2'(i));
      end else begin
        w_state_nxt = ST_LOCK;
      end
    end
  end

  always_ff @(posedge autosa_core_clk) begin
    if (!autosa_core_rstn) r_state <= ST_IDLE;
    else                   r_state <= w_state_nxt;
  end

  always_ff @(posedge autosa_core_clk) begin
    if (!autosa_core_rstn) begin
      r_ptr        <= 2'(NR - 1);
      r_owner      <= '0;
      r_out_pvld   <= 1'b0;
      r_out_data   <= '0;
      r_frame_done <= '0;
    end else begin
      r_ptr        <= w_ptr_nxt;
      r_owner      <= w_owner_nxt;
      r_frame_done <= w_done_nxt;
      if (w_stage_rdy) begin
        r_out_pvld <= w_acc;
        if (w_acc) r_out_data <= w_word;
      end
    end
  end

  assign out_pvld   = r_out_pvld;
  assign out_data   = r_out_data;
  assign arb_owner  = r_owner;
  assign arb_locked = (r_state == ST_LOCK);
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_sa_autosa_sdp_rdma_pack_arb.sv
// Scoreboard bench: per-requester word sources, expected output order queued as
// stimulus is loaded, cycle-level checks of handshake, latency, lock and reset.
module tb_sa_autosa_sdp_rdma_pack_arb;
  localparam int IW = 32;
  localparam int CW = 1;
  localparam int NR = 3;
  localparam int DW = IW + CW;

  logic              clk = 1'b0;
  logic              rstn;
  logic [NR-1:0]     cfg_req_en, req_pvld, req_prdy, frame_done;
  logic [NR*DW-1:0]  req_data;
  logic              out_pvld, out_prdy, arb_locked;
  logic [DW-1:0]     out_data;
  logic [1:0]        arb_owner;

  always #5 clk = ~clk;

  sa_autosa_sdp_rdma_pack_arb #(.IW(IW), .CW(CW), .NR(NR)) dut (
    .autosa_core_clk(clk), .autosa_core_rstn(rstn), .cfg_req_en(cfg_req_en),
    .req_pvld(req_pvld), .req_data(req_data), .req_prdy(req_prdy),
    .out_pvld(out_pvld), .out_data(out_data), .out_prdy(out_prdy),
    .arb_owner(arb_owner), .arb_locked(arb_locked), .frame_done(frame_done));

  int n_vec = 0, n_err = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [DW-1:0] src_mem [NR][64];
  int            src_rd [NR];
  int            src_wr [NR];
  logic [NR-1:0] hold;
  logic [DW-1:0] exp_q [$];
  int            tagc = 0;

  logic          p_rstn = 1'b0, p_acc = 1'b0, p_stall = 1'b0;
  logic [NR-1:0] p_fd = '0;
  logic [DW-1:0] p_data = '0;
  logic [NR-1:0] mon_mask = '0;
  int            lk_req = -1, lk_lo = 0, lk_hi = 0;

  task automatic ld(int i, bit last, bit push);
    logic [DW-1:0] w;
    w = {last, 8'(i), 8'(tagc), 16'(src_wr[i])};
    tagc++;
    src_mem[i][src_wr[i] % 64] = w;
    src_wr[i]++;
    if (push) exp_q.push_back(w);
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      if (src_rd[i] < src_wr[i]) begin
        req_pvld[i] = !hold[i];
        req_data[i*DW +: DW] = src_mem[i][src_rd[i] % 64];
      end else begin
        req_pvld[i] = 1'b0;
        req_data[i*DW +: DW] = '0;
      end
    end
  endtask

  task automatic step();
    logic [NR-1:0] acc, fd_exp;
    logic [DW-1:0] w;
    @(negedge clk);
    acc = req_pvld & req_prdy;
    chk("prdy_1hot", 64'($onehot0(req_prdy)), 64'd1);
    if (!rstn) chk("prdy_rst", 64'(req_prdy), 64'd0);
    if (out_pvld && !out_prdy) chk("prdy_stall", 64'(req_prdy), 64'd0);
    if (!p_rstn) begin
      chk("rst_pvld", 64'(out_pvld), 64'd0);
      chk("rst_lock", 64'(arb_locked), 64'd0);
      chk("rst_data", 64'(out_data), 64'd0);
    end else if (p_stall) begin
      chk("hold_vld", 64'(out_pvld), 64'd1);
      chk("hold_data", 64'(out_data), 64'(p_data));
    end else begin
      chk("lat_vld", 64'(out_pvld), 64'(p_acc));
    end
    chk("frame_done", 64'(frame_done), 64'(p_fd));
    if (mon_mask != 0) chk("en_mask", 64'(req_prdy & mon_mask), 64'd0);
    if (lk_req >= 0 && src_rd[lk_req] >= lk_lo && src_rd[lk_req] <= lk_hi) begin
      chk("locked", 64'(arb_locked), 64'd1);
      chk("owner", 64'(arb_owner), 64'(lk_req));
      chk("lk_others", 64'(req_prdy & ~(NR'(1) << lk_req)), 64'd0);
    end
    if (out_pvld && out_prdy) begin
      if (exp_q.size() == 0) chk("extra_out", 64'(out_pvld & out_prdy), 64'd0);
      else begin
        w = exp_q.pop_front();
        chk("out_data", 64'(out_data), 64'(w));
      end
    end
    for (int i = 0; i < NR; i++) fd_exp[i] = acc[i] & req_data[i*DW + IW];
    p_fd    = rstn ? fd_exp : '0;
    p_rstn  = rstn;
    p_acc   = |acc;
    p_stall = out_pvld & !out_prdy;
    p_data  = out_data;
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) if (acc[i]) src_rd[i]++;
    drive();
  endtask

  task automatic drain(int max);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max) begin
      step();
      n++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    step();
    step();
  endtask

  task automatic run_until_rd(int i, int t, int max);
    int n;
    n = 0;
    while (src_rd[i] < t && n < max) begin
      step();
      n++;
    end
    if (src_rd[i] < t) chk("rd_timeout", 64'(src_rd[i]), 64'(t));
  endtask

  initial begin
    int b;
    logic [3:0] pat;
    rstn = 1'b0; out_prdy = 1'b1; cfg_req_en = '1; hold = '0;
    req_pvld = '0; req_data = '0;
    for (int i = 0; i < NR; i++) begin src_rd[i] = 0; src_wr[i] = 0; end

    // reset with everyone valid, then single-word round robin 0,1,2,0,1,2
    for (int k = 0; k < 2; k++) for (int i = 0; i < NR; i++) ld(i, 1'b1, 1'b1);
    drive();
    repeat (3) step();
    rstn = 1'b1;
    drive();
    drain(50);

    // requester 1 locks a 4-word frame and pauses for 2 cycles mid-frame
    b = src_rd[1];
    for (int k = 0; k < 4; k++) ld(1, k == 3, 1'b1);
    lk_req = 1; lk_lo = b + 1; lk_hi = b + 3;
    drive();
    step();
    ld(2, 1'b1, 1'b1);
    ld(0, 1'b1, 1'b1);
    drive();
    run_until_rd(1, b + 2, 20);
    hold[1] = 1'b1; drive();
    step(); step();
    hold[1] = 1'b0; drive();
    drain(50);
    lk_req = -1;

    // backpressure during a locked frame
    b = src_rd[0];
    for (int k = 0; k < 4; k++) ld(0, k == 3, 1'b1);
    lk_req = 0; lk_lo = b + 1; lk_hi = b + 3;
    drive();
    step();
    pat = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      out_prdy = pat[k];
      step();
    end
    out_prdy = 1'b1;
    drain(50);
    lk_req = -1;

    // enable mask; requester 2 keeps its frame after its enable drops
    cfg_req_en = 3'b101; mon_mask = 3'b010;
    b = src_rd[2];
    ld(2, 1'b1, 1'b1); ld(0, 1'b1, 1'b1);
    ld(2, 1'b0, 1'b1); ld(2, 1'b0, 1'b1); ld(2, 1'b1, 1'b1);
    ld(0, 1'b1, 1'b1);
    ld(1, 1'b1, 1'b0); ld(1, 1'b1, 1'b0);
    lk_req = 2; lk_lo = b + 2; lk_hi = b + 3;
    drive();
    run_until_rd(2, b + 2, 20);
    cfg_req_en[2] = 1'b0;
    drive();
    drain(50);
    mon_mask = '0; lk_req = -1;
    src_rd[1] = src_wr[1];
    cfg_req_en = '1;
    drive();

    // reset in the middle of requester 2's frame
    b = src_rd[2];
    ld(2, 1'b0, 1'b1); ld(2, 1'b0, 1'b1); ld(2, 1'b0, 1'b0); ld(2, 1'b1, 1'b0);
    drive();
    run_until_rd(2, b + 2, 20);
    rstn = 1'b0;
    drive();
    step(); step(); step();
    src_rd[2] = src_wr[2];
    ld(0, 1'b1, 1'b1); ld(1, 1'b1, 1'b1); ld(2, 1'b1, 1'b1);
    rstn = 1'b1;
    drive();
    drain(50);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule
